// File: rtl/led_strip_sequencer.sv
// rtl/led_strip_sequencer.sv - frame sequencer feeding an xx6812 bit encoder from pixel RAM
//
// Walks NUM_LEDS pixel words out of a synchronous pixel RAM, loads each word into
// the encoder, releases the encoder for one 24-bit transmission and waits for its
// done flag before moving on. After the last pixel the line is held idle for the
// latch gap and a one-cycle frame_done is issued. A SEND timeout keeps a stuck
// encoder from hanging the frame.
//
// Ports:
//   clock_3mhz             bit-segment clock, shared with the encoder
//   reset_n                asynchronous active-low reset
//   start                  single-cycle frame request
//   busy                   high from start acceptance until frame_done
//   frame_done             one-cycle pulse at the end of a frame
//   error                  sticky encoder-timeout flag, cleared on accepted start
//   pixel_address          pixel RAM read address
//   pixel_data             pixel RAM read data, valid one cycle after pixel_address
//   encoder_counter_reset  active-high hold/restart for the encoder (low only in SEND)
//   encoder_data           registered parallel word to the encoder
//   encoder_done           encoder transmission-complete flag
//   led_index              index of the pixel currently in flight
module led_strip_sequencer #(
    parameter int NUM_LEDS     = 64,
    parameter int ADDR_WIDTH   = 6,
    parameter int LATCH_CYCLES = 300,
    parameter int SEND_TIMEOUT = 128
) (
    input  logic                  clock_3mhz,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] pixel_address,
    input  logic [23:0]           pixel_data,
    output logic                  encoder_counter_reset,
    output logic [23:0]           encoder_data,
    input  logic                  encoder_done,
    output logic [ADDR_WIDTH-1:0] led_index
);

    localparam int LATCH_WIDTH = $clog2(LATCH_CYCLES + 1);
    localparam int SEND_WIDTH  = $clog2(SEND_TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0]  LAST_INDEX = ADDR_WIDTH'(NUM_LEDS - 1);
    localparam logic [LATCH_WIDTH-1:0] LATCH_LAST = LATCH_WIDTH'(LATCH_CYCLES - 1);
    localparam logic [SEND_WIDTH-1:0]  SEND_LAST  = SEND_WIDTH'(SEND_TIMEOUT - 1);
    localparam logic [SEND_WIDTH-1:0]  SEND_MAX   = SEND_WIDTH'(SEND_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        LATCH
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   busy_next;
    logic                   frame_done_next;
    logic                   error_next;
    logic [ADDR_WIDTH-1:0]  index;
    logic [ADDR_WIDTH-1:0]  index_next;
    logic [23:0]            encoder_data_next;
    logic [SEND_WIDTH-1:0]  send_count;
    logic [SEND_WIDTH-1:0]  send_count_next;
    logic [LATCH_WIDTH-1:0] latch_count;
    logic [LATCH_WIDTH-1:0] latch_count_next;

    // The RAM address and the in-flight index always move together.
    assign pixel_address = index;
    assign led_index     = index;

    always_ff @(posedge clock_3mhz or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            busy                  <= 1'b0;
            frame_done            <= 1'b0;
            error                 <= 1'b0;
            index                 <= '0;
            encoder_data          <= '0;
            encoder_counter_reset <= 1'b1;
            send_count            <= '0;
            latch_count           <= '0;
        end else begin
            state                 <= state_next;
            busy                  <= busy_next;
            frame_done            <= frame_done_next;
            error                 <= error_next;
            index                 <= index_next;
            encoder_data          <= encoder_data_next;
            // Registered from the next state so the encoder is released exactly
            // for the cycles the FSM spends in SEND.
            encoder_counter_reset <= (state_next != SEND);
            send_count            <= send_count_next;
            latch_count           <= latch_count_next;
        end
    end

    always_comb begin
        state_next        = state;
        busy_next         = busy;
        frame_done_next   = 1'b0;
        error_next        = error;
        index_next        = index;
        encoder_data_next = encoder_data;
        send_count_next   = '0;
        latch_count_next  = '0;

        case (state)
            IDLE: begin
                // A start coinciding with the frame_done pulse is dropped.
                if (start && !frame_done) begin
                    error_next = 1'b0;
                    index_next = '0;
                    busy_next  = 1'b1;
                    state_next = FETCH;
                end
            end

            FETCH: begin
                state_next = LOAD;
            end

            LOAD: begin
                encoder_data_next = pixel_data;
                state_next        = SEND;
            end

            SEND: begin
                send_count_next = (send_count == SEND_MAX) ? send_count : send_count + 1'b1;
                // send_count is 0 on the first SEND cycle, where encoder_done may
                // still be left over from the previous pixel.
                if (send_count != '0 && encoder_done) begin
                    if (index == LAST_INDEX) begin
                        state_next = LATCH;
                    end else begin
                        index_next = index + 1'b1;
                        state_next = FETCH;
                    end
                end else if (send_count == SEND_LAST) begin
                    error_next = 1'b1;
                    state_next = LATCH;
                end
            end

            LATCH: begin
                if (latch_count == LATCH_LAST) begin
                    frame_done_next = 1'b1;
                    busy_next       = 1'b0;
                    state_next      = IDLE;
                end else begin
                    latch_count_next = latch_count + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_led_strip_sequencer.sv
// tb/tb_led_strip_sequencer.sv - randomized self-checking bench for led_strip_sequencer
module tb_led_strip_sequencer;

    localparam int N     = 3;
    localparam int LATCH = 300;
    localparam int TMO   = 128;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_STICKY = 1;
    localparam int MODE_STUCK  = 2;

    logic clock_3mhz = 1'b0;
    always #5 clock_3mhz = ~clock_3mhz;

    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        error;
    logic [5:0]  pixel_address;
    logic [23:0] pixel_data = '0;
    logic        encoder_counter_reset;
    logic [23:0] encoder_data;
    logic        encoder_done = 1'b0;
    logic [5:0]  led_index;

    logic        s_start = 1'b0;
    logic        s_busy;
    logic        s_frame_done;
    logic        s_error;
    logic [1:0]  s_pixel_address;
    logic [23:0] s_pixel_data = '0;
    logic        s_encoder_counter_reset;
    logic [23:0] s_encoder_data;
    logic        s_encoder_done = 1'b0;
    logic [1:0]  s_led_index;

    led_strip_sequencer #(
        .NUM_LEDS(N), .ADDR_WIDTH(6), .LATCH_CYCLES(LATCH), .SEND_TIMEOUT(TMO)
    ) dut (
        .clock_3mhz(clock_3mhz), .reset_n(reset_n), .start(start), .busy(busy),
        .frame_done(frame_done), .error(error), .pixel_address(pixel_address),
        .pixel_data(pixel_data), .encoder_counter_reset(encoder_counter_reset),
        .encoder_data(encoder_data), .encoder_done(encoder_done), .led_index(led_index)
    );

    led_strip_sequencer #(
        .NUM_LEDS(1), .ADDR_WIDTH(2), .LATCH_CYCLES(1), .SEND_TIMEOUT(TMO)
    ) dut_small (
        .clock_3mhz(clock_3mhz), .reset_n(reset_n), .start(s_start), .busy(s_busy),
        .frame_done(s_frame_done), .error(s_error), .pixel_address(s_pixel_address),
        .pixel_data(s_pixel_data), .encoder_counter_reset(s_encoder_counter_reset),
        .encoder_data(s_encoder_data), .encoder_done(s_encoder_done), .led_index(s_led_index)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Synchronous pixel RAMs
    logic [23:0] ram   [64];
    logic [23:0] s_ram [4];
    always @(posedge clock_3mhz) pixel_data   <= ram[pixel_address];
    always @(posedge clock_3mhz) s_pixel_data <= s_ram[s_pixel_address];

    // Behavioural encoder: 24 bits x 4 cycles MSB first, done after 96 released cycles.
    // STICKY raises done while held in reset so the first SEND cycle sees a stale flag;
    // STUCK never raises done.
    int          enc_mode = MODE_NORMAL;
    int          enc_cnt  = 0;
    logic [23:0] enc_shift = '0;
    logic [23:0] sent_q[$];
    logic [23:0] load_q[$];
    logic        ecr_prev = 1'b1;

    always @(posedge clock_3mhz) begin
        if (encoder_counter_reset) begin
            enc_cnt      <= 0;
            encoder_done <= (enc_mode == MODE_STICKY);
        end else begin
            if (enc_cnt == 0 && enc_mode == MODE_STICKY) encoder_done <= 1'b0;
            if (enc_cnt < 96) begin
                enc_cnt <= enc_cnt + 1;
                if (enc_cnt % 4 == 0) enc_shift <= {enc_shift[22:0], encoder_data[23 - enc_cnt / 4]};
                if (enc_cnt == 95) begin
                    sent_q.push_back(enc_shift);
                    if (enc_mode != MODE_STUCK) encoder_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clock_3mhz) begin
        if (ecr_prev && !encoder_counter_reset) load_q.push_back(encoder_data);
        ecr_prev = encoder_counter_reset;
    end

    int          s_cnt = 0;
    logic [23:0] s_shift = '0;
    always @(posedge clock_3mhz) begin
        if (s_encoder_counter_reset) begin
            s_cnt          <= 0;
            s_encoder_done <= 1'b0;
        end else if (s_cnt < 96) begin
            s_cnt <= s_cnt + 1;
            if (s_cnt % 4 == 0) s_shift <= {s_shift[22:0], s_encoder_data[23 - s_cnt / 4]};
            if (s_cnt == 95) s_encoder_done <= 1'b1;
        end
    end

    task automatic check_reset_values(input string tag);
        check($sformatf("%s busy", tag), busy, 0);
        check($sformatf("%s frame_done", tag), frame_done, 0);
        check($sformatf("%s error", tag), error, 0);
        check($sformatf("%s pixel_address", tag), pixel_address, 0);
        check($sformatf("%s led_index", tag), led_index, 0);
        check($sformatf("%s encoder_data", tag), encoder_data, 0);
        check($sformatf("%s encoder_counter_reset", tag), encoder_counter_reset, 1);
    endtask

    // Called just after a negedge. Expectations come from the frame rules:
    // each pixel costs 1+1+97 cycles (1+1+TMO when the encoder is stuck, and the
    // frame aborts), plus the start cycle, the latch gap and the frame_done cycle.
    task automatic run_frame(input string tag, input int mode, input bit noise,
                             input bit chain, input int reset_at);
        logic [23:0] exp_q[$];
        int exp_len;
        int cyc;
        int noise_cyc;
        int latch_noise;
        bit seen;
        enc_mode = mode;
        exp_q = {};
        if (mode == MODE_STUCK) begin
            exp_q.push_back(ram[0]);
            exp_len = 2 + (2 + TMO) + LATCH;
        end else begin
            for (int i = 0; i < N; i++) exp_q.push_back(ram[i]);
            exp_len = 2 + 99 * N + LATCH;
        end
        sent_q = {};
        load_q = {};
        noise_cyc   = $urandom_range(5, exp_len - LATCH - 5);
        latch_noise = $urandom_range(exp_len - LATCH, exp_len - 4);
        start = 1'b1;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < exp_len + 200) begin
            @(negedge clock_3mhz);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                check($sformatf("%s busy after start", tag), busy, 1);
                check($sformatf("%s error cleared on start", tag), error, 0);
                check($sformatf("%s first address", tag), pixel_address, 0);
                check($sformatf("%s encoder held in FETCH", tag), encoder_counter_reset, 1);
            end
            if (cyc == 2) check($sformatf("%s encoder held in LOAD", tag), encoder_counter_reset, 1);
            if (cyc == 3) check($sformatf("%s encoder released in SEND", tag), encoder_counter_reset, 0);
            if (reset_at != 0 && cyc == reset_at) begin
                check($sformatf("%s pixel 1 in flight", tag), led_index, 1);
                #2 reset_n = 1'b0;
                #1 check_reset_values($sformatf("%s mid-frame reset", tag));
                repeat (2) @(negedge clock_3mhz);
                check($sformatf("%s no frame_done after reset", tag), frame_done, 0);
                reset_n = 1'b1;
                return;
            end
            if (noise && (cyc == noise_cyc || cyc == latch_noise)) start = 1'b1;
            if (frame_done) seen = 1;
        end
        check($sformatf("%s frame length", tag), cyc + 1, exp_len);
        check($sformatf("%s busy drops with frame_done", tag), busy, 0);
        check($sformatf("%s error flag", tag), error, (mode == MODE_STUCK));
        check($sformatf("%s final led_index", tag), led_index, (mode == MODE_STUCK) ? 0 : N - 1);
        check($sformatf("%s decoded word count", tag), sent_q.size(), exp_q.size());
        check($sformatf("%s loaded word count", tag), load_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s decoded word %0d", tag, i), (i < sent_q.size()) ? sent_q[i] : 24'hxxxxxx, exp_q[i]);
            check($sformatf("%s loaded word %0d", tag, i), (i < load_q.size()) ? load_q[i] : 24'hxxxxxx, exp_q[i]);
        end
        if (chain) begin
            start = 1'b1;
            @(negedge clock_3mhz);
            check($sformatf("%s start on frame_done ignored", tag), busy, 0);
            check($sformatf("%s frame_done single cycle", tag), frame_done, 0);
        end else begin
            @(negedge clock_3mhz);
            check($sformatf("%s frame_done single cycle", tag), frame_done, 0);
            repeat (3) @(negedge clock_3mhz);
            check($sformatf("%s no queued frame", tag), busy, 0);
        end
    endtask

    task automatic run_small(input logic [23:0] word);
        int cyc;
        bit seen;
        s_ram[0] = word;
        s_start = 1'b1;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 400) begin
            @(negedge clock_3mhz);
            cyc++;
            s_start = 1'b0;
            if (s_frame_done) seen = 1;
        end
        check("small frame length", cyc + 1, 2 + 99 + 1);
        check("small decoded word", s_shift, word);
        check("small busy drops", s_busy, 0);
        check("small error", s_error, 0);
        check("small led_index", s_led_index, 0);
        repeat (2) @(negedge clock_3mhz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = '0;
        for (int i = 0; i < 4; i++) s_ram[i] = '0;
        repeat (3) @(negedge clock_3mhz);
        check_reset_values("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clock_3mhz);
        check("idle after reset", busy, 0);

        ram[0] = 24'h00FF00;
        ram[1] = 24'hFF0000;
        ram[2] = 24'h0000FF;
        run_frame("plan", MODE_NORMAL, 1'b1, 1'b1, 0);
        for (int i = 0; i < N; i++) ram[i] = 24'($urandom);
        run_frame("chained", MODE_NORMAL, 1'b0, 1'b0, 0);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) ram[i] = 24'($urandom);
            run_frame($sformatf("rand%0d", f), ($urandom_range(0, 1) == 0) ? MODE_NORMAL : MODE_STICKY,
                      1'b1, 1'b0, 0);
        end

        run_frame("stuck", MODE_STUCK, 1'b1, 1'b0, 0);
        for (int i = 0; i < N; i++) ram[i] = 24'($urandom);
        run_frame("reset", MODE_NORMAL, 1'b0, 1'b0, 150);
        run_frame("replay", MODE_STICKY, 1'b0, 1'b0, 0);

        run_small(24'($urandom));
        run_small(24'hA5C30F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
